// File: rtl/host_byte_deframer.sv
// host_byte_deframer: parses framed host bytes into command, conf and 64-bit
// data words for the serial command core. One assembled data word can be
// parked while the output register is still waiting on the core.
module host_byte_deframer #(
  parameter int CMD_WIDTH  = 16,
  parameter int CONF_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_isReady,
  output logic                  byte_canReceive,
  output logic [CMD_WIDTH-1:0]  cmd,
  output logic                  cmd_hasAny,
  input  logic                  cmd_consume,
  output logic [63:0]           out,
  output logic                  out_isReady,
  input  logic                  out_canReceive,
  output logic [CONF_WIDTH-1:0] conf,
  output logic                  err
);

  localparam int CMD_BYTES  = (CMD_WIDTH + 7) / 8;
  localparam int CONF_BYTES = (CONF_WIDTH + 7) / 8;
  localparam int CMD_SR_W   = CMD_BYTES * 8;
  localparam int CONF_SR_W  = CONF_BYTES * 8;

  localparam logic [7:0] HDR_CMD   = 8'h01;
  localparam logic [7:0] HDR_CONF  = 8'h02;
  localparam logic [7:0] HDR_DATA  = 8'h03;
  localparam logic [7:0] CMD_LAST  = 8'(CMD_BYTES - 1);
  localparam logic [7:0] CONF_LAST = 8'(CONF_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_CONF,
    S_LEN,
    S_DATA
  } state_t;

  state_t                 state;
  logic [7:0]             fld_cnt;
  logic [7:0]             words_left;
  logic [2:0]             byte_idx;
  logic [CMD_SR_W-1:0]    cmd_sr;
  logic [CONF_SR_W-1:0]   conf_sr;
  logic [63:0]            asm_word;
  logic [63:0]            word_now;
  logic                   asm_full;
  logic                   byte_xfer;
  logic                   drain;
  logic                   out_free;
  logic                   cmd_last_byte;

  // Only the byte that would overwrite a pending command is held back;
  // earlier command bytes keep assembling in the shift register.
  assign cmd_last_byte   = (state == S_CMD) && (fld_cnt == CMD_LAST);
  assign byte_canReceive = rst && !asm_full && !(cmd_last_byte && cmd_hasAny);
  assign byte_xfer       = byte_isReady && byte_canReceive;
  assign drain           = out_isReady && out_canReceive;
  assign out_free        = !out_isReady || drain;

  // Assembly word with the current byte dropped into its big-endian slot
  always_comb begin
    word_now = asm_word;
    word_now[{~byte_idx, 3'b000} +: 8] = byte_in;
  end

  // Field shift registers and word assembly; contents are fully rewritten
  // by every frame, so they carry no reset
  always_ff @(posedge clk) begin
    if (byte_xfer) begin
      case (state)
        S_CMD:   cmd_sr   <= CMD_SR_W'({cmd_sr, byte_in});
        S_CONF:  conf_sr  <= CONF_SR_W'({conf_sr, byte_in});
        S_DATA:  asm_word <= word_now;
        default: ;
      endcase
    end
  end

  // Frame parser FSM plus registered command, conf and output-word state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      fld_cnt     <= 8'd0;
      words_left  <= 8'd0;
      byte_idx    <= 3'd0;
      asm_full    <= 1'b0;
      out         <= 64'd0;
      out_isReady <= 1'b0;
      cmd         <= '0;
      cmd_hasAny  <= 1'b0;
      conf        <= '0;
      err         <= 1'b0;
    end else begin
      if (cmd_consume && cmd_hasAny)
        cmd_hasAny <= 1'b0;

      // A parked word moves as soon as the output register frees up; no byte
      // can complete a word in the same cycle because input is stalled.
      if (asm_full && out_free) begin
        out         <= asm_word;
        out_isReady <= 1'b1;
        asm_full    <= 1'b0;
      end else if (drain) begin
        out_isReady <= 1'b0;
      end

      if (byte_xfer) begin
        case (state)
          S_IDLE: begin
            fld_cnt <= 8'd0;
            case (byte_in)
              HDR_CMD:  state <= S_CMD;
              HDR_CONF: state <= S_CONF;
              HDR_DATA: state <= S_LEN;
              default:  err   <= 1'b1;
            endcase
          end
          S_CMD: begin
            if (cmd_last_byte) begin
              cmd        <= CMD_WIDTH'({cmd_sr, byte_in});
              cmd_hasAny <= 1'b1;
              state      <= S_IDLE;
            end else begin
              fld_cnt <= fld_cnt + 8'd1;
            end
          end
          S_CONF: begin
            if (fld_cnt == CONF_LAST) begin
              conf  <= CONF_WIDTH'({conf_sr, byte_in});
              state <= S_IDLE;
            end else begin
              fld_cnt <= fld_cnt + 8'd1;
            end
          end
          S_LEN: begin
            words_left <= byte_in;
            byte_idx   <= 3'd0;
            state      <= (byte_in == 8'd0) ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            byte_idx <= byte_idx + 3'd1;
            if (byte_idx == 3'd7) begin
              // A refill during a drain overrides the drain's clear above,
              // so the core sees back-to-back words without a bubble.
              if (out_free) begin
                out         <= word_now;
                out_isReady <= 1'b1;
              end else begin
                asm_full <= 1'b1;
              end
              words_left <= words_left - 8'd1;
              if (words_left == 8'd1)
                state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_host_byte_deframer.sv
// Testbench for host_byte_deframer: directed frames followed by randomized
// frames with random core backpressure, checked against a word queue and
// field values computed from the frame bytes.
module tb_host_byte_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_isReady;
  logic        byte_canReceive;
  logic [15:0] cmd;
  logic        cmd_hasAny;
  logic        cmd_consume;
  logic [63:0] out;
  logic        out_isReady;
  logic        out_canReceive;
  logic [19:0] conf;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int words_rx = 0;
  int words_pushed = 0;
  bit done = 1'b0;
  logic [63:0] exp_q[$];

  host_byte_deframer #(.CMD_WIDTH(16), .CONF_WIDTH(20)) dut (
    .clk(clk),
    .rst(rst),
    .byte_in(byte_in),
    .byte_isReady(byte_isReady),
    .byte_canReceive(byte_canReceive),
    .cmd(cmd),
    .cmd_hasAny(cmd_hasAny),
    .cmd_consume(cmd_consume),
    .out(out),
    .out_isReady(out_isReady),
    .out_canReceive(out_canReceive),
    .conf(conf),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Every word the core accepts must be the next one the frames produced
  always @(negedge clk) begin
    if (rst === 1'b1 && out_isReady === 1'b1 && out_canReceive === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_word: observed %h, expected no word", out);
      end else begin
        check("word", out, exp_q.pop_front());
      end
      words_rx++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    byte_in = b;
    byte_isReady = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (byte_canReceive === 1'b1) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) begin
      @(posedge clk);
      #1;
    end else begin
      n_checks++;
      n_fail++;
      $error("FAIL byte_accept_timeout: observed no transfer of %h, expected a transfer", b);
    end
    byte_isReady = 1'b0;
  endtask

  task automatic consume_cmd();
    cmd_consume = 1'b1;
    idle(1);
    cmd_consume = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) idle(1);
    idle(2);
    check(tag, exp_q.size(), 0);
    check({tag, "_count"}, words_rx, words_pushed);
  endtask

  function automatic logic [63:0] seq_word(input int start);
    logic [63:0] w;
    w = 64'd0;
    for (int i = 0; i < 8; i++) w = (w << 8) | 64'(start + i);
    return w;
  endfunction

  initial begin
    rst = 1'b0;
    byte_in = 8'h00;
    byte_isReady = 1'b0;
    cmd_consume = 1'b0;
    out_canReceive = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_canReceive", byte_canReceive, 0);
    check("rst_cmd", cmd, 0);
    check("rst_hasAny", cmd_hasAny, 0);
    check("rst_out", out, 0);
    check("rst_isReady", out_isReady, 0);
    check("rst_conf", conf, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    idle(1);
    check("idle_canReceive", byte_canReceive, 1);

    // Command frame, held until consumed
    send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
    check("t1_cmd", cmd, 16'hABCD);
    check("t1_hasAny", cmd_hasAny, 1);
    idle(5);
    check("t1_hold", cmd_hasAny, 1);
    consume_cmd();
    check("t1_consumed", cmd_hasAny, 0);

    // Two words, core always ready
    out_canReceive = 1'b1;
    exp_q.push_back(seq_word(8'h01)); words_pushed++;
    exp_q.push_back(seq_word(8'h11)); words_pushed++;
    send_byte(8'h03); send_byte(8'h02);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) send_byte(8'((w == 0 ? 8'h01 : 8'h11) + i));
      check("t2_latency", out_isReady, 1);
      check("t2_out", out, seq_word(w == 0 ? 8'h01 : 8'h11));
    end
    wait_drain("t2_drain");

    // Two words, core stalled until both are buffered
    out_canReceive = 1'b0;
    exp_q.push_back(seq_word(8'h01)); words_pushed++;
    exp_q.push_back(seq_word(8'h11)); words_pushed++;
    send_byte(8'h03); send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h01 + i));
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i));
    check("t3_stall", byte_canReceive, 0);
    check("t3_isReady", out_isReady, 1);
    check("t3_out", out, seq_word(8'h01));
    idle(2);
    check("t3_still_stall", byte_canReceive, 0);
    out_canReceive = 1'b1;
    idle(1);
    check("t3_b2b_isReady", out_isReady, 1);
    check("t3_b2b_out", out, seq_word(8'h11));
    check("t3_resume", byte_canReceive, 1);
    wait_drain("t3_drain");

    // Second command stalls on its final byte while the first is pending
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    check("t4_cmd1", cmd, 16'h0001);
    check("t4_hasAny1", cmd_hasAny, 1);
    send_byte(8'h01); send_byte(8'h00);
    byte_in = 8'h02;
    byte_isReady = 1'b1;
    idle(3);
    check("t4_final_stall", byte_canReceive, 0);
    check("t4_cmd_held", cmd, 16'h0001);
    consume_cmd();
    check("t4_unstall", byte_canReceive, 1);
    idle(1);
    byte_isReady = 1'b0;
    check("t4_cmd2", cmd, 16'h0002);
    check("t4_hasAny2", cmd_hasAny, 1);
    consume_cmd();

    // Bad header, conf frame, zero-length data frame
    send_byte(8'h7F);
    check("t5_err", err, 1);
    check("t5_hasAny", cmd_hasAny, 0);
    check("t5_isReady", out_isReady, 0);
    check("t5_conf0", conf, 0);
    send_byte(8'h02); send_byte(8'h0A); send_byte(8'hBC); send_byte(8'hDE);
    check("t5_conf", conf, 20'hABCDE);
    check("t5_err_sticky", err, 1);
    send_byte(8'h03); send_byte(8'h00);
    idle(2);
    check("t5_len0_noword", out_isReady, 0);
    send_byte(8'h01); send_byte(8'h5A); send_byte(8'hA5);
    check("t5_idle_after_len0", cmd, 16'h5AA5);
    consume_cmd();

    // Random frames with random core backpressure
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          int kind;
          logic [7:0] b0, b1, b2;
          kind = $urandom_range(0, 2);
          b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
          if (kind == 0) begin
            send_byte(8'h01); send_byte(b0);
            if ($urandom_range(0, 2) == 0) idle(1);
            send_byte(b1);
            check("rand_cmd", cmd, {b0, b1});
            check("rand_hasAny", cmd_hasAny, 1);
            consume_cmd();
          end else if (kind == 1) begin
            int v;
            send_byte(8'h02); send_byte(b0); send_byte(b1);
            if ($urandom_range(0, 2) == 0) idle(1);
            send_byte(b2);
            v = (int'(b0) << 16) | (int'(b1) << 8) | int'(b2);
            check("rand_conf", conf, v & 32'h000F_FFFF);
          end else begin
            int nw;
            nw = $urandom_range(0, 4);
            send_byte(8'h03); send_byte(8'(nw));
            for (int w = 0; w < nw; w++) begin
              logic [7:0] bytes[8];
              logic [63:0] wv;
              wv = 64'd0;
              for (int i = 0; i < 8; i++) begin
                bytes[i] = 8'($urandom);
                wv = (wv << 8) | 64'(bytes[i]);
              end
              exp_q.push_back(wv);
              words_pushed++;
              for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 5) == 0) idle(1);
                send_byte(bytes[i]);
              end
            end
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_canReceive = 1'($urandom_range(0, 1));
          idle(1);
        end
        out_canReceive = 1'b1;
      end
    join
    wait_drain("rand_drain");

    // Asynchronous reset in the middle of a word with cmd and conf live
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h02); send_byte(8'h0F); send_byte(8'hFF); send_byte(8'hFF);
    check("t6_conf_pre", conf, 20'hFFFFF);
    check("t6_hasAny_pre", cmd_hasAny, 1);
    out_canReceive = 1'b0;
    send_byte(8'h03); send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h51 + i));
    #2;
    rst = 1'b0;
    #1;
    check("t6_cmd", cmd, 0);
    check("t6_hasAny", cmd_hasAny, 0);
    check("t6_out", out, 0);
    check("t6_isReady", out_isReady, 0);
    check("t6_conf", conf, 0);
    check("t6_err", err, 0);
    check("t6_canReceive", byte_canReceive, 0);
    #2;
    rst = 1'b1;
    idle(1);
    check("t6_release_canReceive", byte_canReceive, 1);
    out_canReceive = 1'b1;
    exp_q.push_back(seq_word(8'hA1)); words_pushed++;
    send_byte(8'h03); send_byte(8'h01);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA1 + i));
    check("t6_word_ready", out_isReady, 1);
    check("t6_word", out, seq_word(8'hA1));
    wait_drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
